// File: rtl/median3x3_pipe.sv
// median3x3_pipe: streaming 3x3 rank filter (median/max/min/centre) over sorted columns.
// Stages: column sort, sliding window, partial ranks, final select; out_valid three edges after the completing column.
module median3x3_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk_100M,
    input  logic              rst_p,
    input  logic              in_valid,
    input  logic              in_sol,
    input  logic [DATA_W-1:0] col_top,
    input  logic [DATA_W-1:0] col_mid,
    input  logic [DATA_W-1:0] col_bot,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic              out_sol,
    output logic [DATA_W-1:0] pixel_out
);
    typedef logic [DATA_W-1:0] pix_t;
    typedef struct packed {
        pix_t hi;
        pix_t md;
        pix_t lo;
    } col_t;

    function automatic pix_t mx(pix_t a, pix_t b);
        return a >= b ? a : b;
    endfunction

    function automatic pix_t mn(pix_t a, pix_t b);
        return a >= b ? b : a;
    endfunction

    function automatic pix_t md3(pix_t a, pix_t b, pix_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    logic       s1_v, s1_sol;
    col_t       s1c;
    pix_t       s1_mid;
    logic [1:0] s1_mode;

    col_t       w0, w1, w2;
    pix_t       w1_mid, w2_mid;
    logic [1:0] fcnt, fcnt_n, w_mode;
    logic       pend, wv, w_first, full_n;

    logic       s2_v, s2_first;
    logic [1:0] s2_mode;
    pix_t       s2_lomax, s2_mdmed, s2_himin, s2_gmax, s2_gmin, s2_ctr;

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            s1_v    <= 1'b0;
            s1_sol  <= 1'b0;
            s1c     <= '0;
            s1_mid  <= '0;
            s1_mode <= '0;
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1c.hi  <= mx(mx(col_top, col_mid), col_bot);
                s1c.md  <= md3(col_top, col_mid, col_bot);
                s1c.lo  <= mn(mn(col_top, col_mid), col_bot);
                s1_mid  <= col_mid;
                s1_mode <= mode;
                s1_sol  <= in_sol;
            end
        end
    end

    always_comb begin
        fcnt_n = s1_sol ? 2'd1 : (fcnt == 2'd3 ? 2'd3 : fcnt + 2'd1);
        full_n = fcnt_n == 2'd3;
    end

    // pend remembers a start-of-line until its first full window, which carries the line-first flag
    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            w0      <= '0;
            w1      <= '0;
            w2      <= '0;
            w1_mid  <= '0;
            w2_mid  <= '0;
            fcnt    <= '0;
            pend    <= 1'b0;
            wv      <= 1'b0;
            w_first <= 1'b0;
            w_mode  <= '0;
        end else begin
            wv <= s1_v && full_n;
            if (s1_v) begin
                w0      <= w1;
                w1      <= w2;
                w2      <= s1c;
                w1_mid  <= w2_mid;
                w2_mid  <= s1_mid;
                fcnt    <= fcnt_n;
                pend    <= (pend | s1_sol) & ~full_n;
                w_first <= (pend | s1_sol) & full_n;
                w_mode  <= s1_mode;
            end
        end
    end

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_mode  <= '0;
            s2_lomax <= '0;
            s2_mdmed <= '0;
            s2_himin <= '0;
            s2_gmax  <= '0;
            s2_gmin  <= '0;
            s2_ctr   <= '0;
        end else begin
            s2_v <= wv;
            if (wv) begin
                s2_lomax <= mx(mx(w0.lo, w1.lo), w2.lo);
                s2_mdmed <= md3(w0.md, w1.md, w2.md);
                s2_himin <= mn(mn(w0.hi, w1.hi), w2.hi);
                s2_gmax  <= mx(mx(w0.hi, w1.hi), w2.hi);
                s2_gmin  <= mn(mn(w0.lo, w1.lo), w2.lo);
                s2_ctr   <= w1_mid;
                s2_mode  <= w_mode;
                s2_first <= w_first;
            end
        end
    end

    always_ff @(posedge clk_100M or posedge rst_p) begin
        if (rst_p) begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            pixel_out <= '0;
        end else begin
            out_valid <= s2_v;
            out_sol   <= s2_v & s2_first;
            if (s2_v)
                pixel_out <= s2_mode == 2'd0 ? md3(s2_lomax, s2_mdmed, s2_himin) :
                             s2_mode == 2'd1 ? s2_gmax :
                             s2_mode == 2'd2 ? s2_gmin : s2_ctr;
        end
    end
endmodule

// File: tb/tb_median3x3_pipe.sv
// tb_median3x3_pipe: directed vectors into 8-bit and 10-bit instances; scoreboard monitor checks value, sol and arrival cycle.
module tb_median3x3_pipe;
    typedef struct {
        int val;
        bit sol;
        int due;
    } exp_t;

    logic       clk_100M = 1'b0;
    logic       rst_p = 1'b1;
    logic       iv8 = 1'b0, is8 = 1'b0, ov8, os8;
    logic [7:0] t8 = '0, m8 = '0, b8 = '0, px8;
    logic [1:0] md8 = '0;
    logic       iv10 = 1'b0, is10 = 1'b0, ov10, os10;
    logic [9:0] t10 = '0, m10 = '0, b10 = '0, px10;
    logic [1:0] md10 = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q10[$];

    median3x3_pipe #(.DATA_W(8)) dut8 (
        .clk_100M(clk_100M), .rst_p(rst_p), .in_valid(iv8), .in_sol(is8),
        .col_top(t8), .col_mid(m8), .col_bot(b8), .mode(md8),
        .out_valid(ov8), .out_sol(os8), .pixel_out(px8)
    );

    median3x3_pipe #(.DATA_W(10)) dut10 (
        .clk_100M(clk_100M), .rst_p(rst_p), .in_valid(iv10), .in_sol(is10),
        .col_top(t10), .col_mid(m10), .col_bot(b10), .mode(md10),
        .out_valid(ov10), .out_sol(os10), .pixel_out(px10)
    );

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input string name, input int px, input bit os, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            check({name, " unexpected out_valid"}, 1, 0);
        end else begin
            e = q.pop_front();
            check({name, " pixel"}, px, e.val);
            check({name, " sol"}, int'(os), int'(e.sol));
            check({name, " cycle"}, cyc, e.due);
        end
    endtask

    always @(negedge clk_100M) begin
        if (ov8) mon("w8", int'(px8), os8, q8);
        if (ov10) mon("w10", int'(px10), os10, q10);
    end

    task automatic col8(input int t, input int m, input int b, input bit s, input int md);
        @(posedge clk_100M);
        #1;
        iv8 = 1'b1; is8 = s; t8 = 8'(t); m8 = 8'(m); b8 = 8'(b); md8 = 2'(md);
    endtask

    task automatic col10(input int t, input int m, input int b, input bit s, input int md);
        @(posedge clk_100M);
        #1;
        iv10 = 1'b1; is10 = s; t10 = 10'(t); m10 = 10'(m); b10 = 10'(b); md10 = 2'(md);
    endtask

    task automatic exp8(input int v, input bit s);
        q8.push_back('{val: v, sol: s, due: cyc + 4});
    endtask

    task automatic exp10(input int v, input bit s);
        q10.push_back('{val: v, sol: s, due: cyc + 4});
    endtask

    // idle cycles keep in_sol high to show it is ignored without in_valid
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_100M);
            #1;
            iv8 = 1'b0; is8 = 1'b1; iv10 = 1'b0; is10 = 1'b1;
        end
    endtask

    task automatic basic(input int md);
        col8(9, 1, 5, 1, md);
        col8(2, 8, 3, 0, md);
        col8(7, 4, 6, 0, md);
    endtask

    initial begin
        int modes[5] = '{0, 0, 1, 2, 0};
        int res[4] = '{5, 9, 1, 8};
        repeat (3) @(posedge clk_100M);
        #1;
        check("reset pixel_out", int'(px8), 0);
        check("reset out_valid", int'(ov8), 0);
        check("reset out_sol", int'(os8), 0);
        check("reset out_valid w10", int'(ov10), 0);
        rst_p = 1'b0;
        idle(2);

        for (int m = 0; m < 4; m++) begin
            basic(m);
            exp8(res[m], 1);
            idle(6);
        end

        for (int k = 1; k <= 5; k++) begin
            col8(k, k, k, k == 1, modes[k-1]);
            if (k == 3) exp8(3, 1);
            if (k == 4) exp8(2, 0);
            if (k == 5) exp8(4, 0);
        end
        idle(6);

        col8(9, 1, 5, 1, 0);
        idle(2);
        col8(2, 8, 3, 0, 0);
        idle(2);
        col8(7, 4, 6, 0, 0);
        exp8(5, 1);
        idle(6);

        col8(1, 2, 3, 1, 0);
        col8(4, 5, 6, 0, 0);
        col8(7, 8, 9, 0, 0);
        exp8(5, 1);
        col8(10, 11, 12, 0, 0);
        exp8(8, 0);
        col8(20, 21, 22, 1, 0);
        col8(23, 24, 25, 0, 0);
        col8(26, 27, 28, 0, 0);
        exp8(24, 1);
        idle(6);

        basic(0);
        exp8(5, 1);
        col8(1, 2, 3, 0, 0);
        repeat (4) begin
            @(posedge clk_100M);
            #1;
            iv8 = 1'b0; is8 = 1'b0;
        end
        #1;
        rst_p = 1'b1;
        #1;
        check("rst mid pixel_out", int'(px8), 0);
        check("rst mid out_valid", int'(ov8), 0);
        check("rst mid out_sol", int'(os8), 0);
        idle(2);
        rst_p = 1'b0;
        idle(6);
        check("queue after reset", q8.size(), 0);

        col10(1023, 0, 1023, 1, 0);
        col10(0, 1023, 0, 0, 0);
        col10(1023, 1023, 0, 0, 0);
        exp10(1023, 1);
        idle(6);
        col10(0, 0, 1023, 1, 0);
        col10(1023, 0, 0, 0, 0);
        col10(0, 1023, 0, 0, 0);
        exp10(0, 1);
        idle(6);
        col10(0, 0, 1023, 1, 1);
        col10(1023, 0, 0, 0, 1);
        col10(0, 1023, 0, 0, 1);
        exp10(1023, 1);
        col10(1023, 1023, 1023, 0, 2);
        exp10(0, 0);
        idle(8);

        check("final queue w8", q8.size(), 0);
        check("final queue w10", q10.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/median3x3_pipe.md
# median3x3_pipe

Pipelined 3×3-window rank filter for the ball-locator video path. Per valid cycle it accepts one vertical 3-pixel column from the upstream line buffers. It keeps a sliding window of the last three columns and outputs the window median, maximum, minimum or centre pixel, selected per pixel. It is the parametrised, streaming successor to the single-stage 3-input sorter. It adds width generalisation, valid/start-of-line tracking, window fill control and a fixed-latency pipeline.

## Interface
- DATA_W, 8, pixel width in bits (≥2)
- clk_100M  in  1  clock, all logic on rising edge
- rst_p  in  1  reset, asynchronous, active-high
- in_valid  in  1  column qualifier; all other inputs ignored when low
- in_sol  in  1  start of line; qualified by in_valid; marks first column of a line
- col_top  in  DATA_W  window row 0 pixel of incoming column
- col_mid  in  DATA_W  window row 1 pixel (centre row)
- col_bot  in  DATA_W  window row 2 pixel
- mode  in  2  00 median, 01 max, 10 min, 11 bypass centre; sampled with in_valid
- out_valid  out  1  pixel_out qualifier, one-cycle pulse per output pixel
- out_sol  out  1  high with the first out_valid of each line
- pixel_out  out  DATA_W  filtered pixel

## Operation
- S1, column sort, registered on every in_valid cycle:
  - Sort the column into cmax/cmed/cmin. Comparisons unsigned with ≥; ties resolved arbitrarily, since the value set is what matters.
  - Also carry the raw col_mid, mode and in_sol.
- Window: three sorted-column slots W0 (oldest), W1, W2 (newest). They shift only when the S1 valid bit is set; the window holds during bubbles.
- Fill counter fcnt, 2 bits, saturating at 3:
  - On an S1 column with sol=1: fcnt←1, and the column is written to W2. Older slots are don't-care.
  - Otherwise fcnt←min(fcnt+1,3).
  - Window is full when the post-update fcnt = 3.
- S2, registered when S1 is valid and the window is full:
  - lo_max = max(W0.cmin, W1.cmin, W2.cmin)
  - md_med = med(W0.cmed, W1.cmed, W2.cmed)
  - hi_min = min(W0.cmax, W1.cmax, W2.cmax)
  - gmax = max of cmax
  - gmin = min of cmin
  - centre = raw col_mid of W1
- S2 also carries mode and a line-first flag. The line-first flag is set for the first full window after sol.
- S3, registered:
  - median = med(lo_max, md_med, hi_min), which is exact for 9 values.
  - pixel_out is chosen by the carried mode: median / gmax / gmin / centre.
  - out_valid is set; out_sol is taken from the line-first flag.
- Per-stage valid bits advance every cycle; there is no backpressure and no stall. Downstream must accept every out_valid.
- Mode is per pixel: a mode change takes effect on the pixel whose completing column carried it.
- Columns before the window is full (first two of each line) produce no output. Each line of L columns yields L−2 outputs.
- in_sol high with in_valid low is ignored.

## Timing
- Latency: the completing column is sampled at edge T; out_valid/pixel_out are registered at edge T+3 (three-stage pipeline).
- Throughput: one pixel per cycle with back-to-back in_valid. Bubbles propagate unchanged with the same spacing.
- out_valid is high only in the cycle after S3 loads. pixel_out holds its last value when out_valid is low.
- Reset values, all cleared asynchronously on rst_p:
  - pixel_out = 0, out_valid = 0, out_sol = 0
  - fcnt = 0, all window slots and stage registers = 0, all valid bits = 0
- Reset mid-line: in-flight pixels are dropped, with no out_valid after reset. The next line requires in_sol; columns without a prior sol still fill fcnt from 0.
- in_sol arriving mid-line: the window restarts as above. Pixels already in S2/S3 still emerge at their scheduled cycles.
- Arithmetic: no width growth; results are always one of the input values.

## Test plan
- Basic fill, mode=00, back-to-back columns (9,1,5) with sol, then (2,8,3), then (7,4,6) → out_valid low for first two columns; at T+3 after third column, pixel_out=5 with out_sol=1.
- Same three columns with mode 01/10/11 → 9 / 1 / 8.
- Mode changes per column across 5-column line:
  - Stimulus: (1,1,1),(2,2,2),(3,3,3),(4,4,4),(5,5,5) with modes 00,00,01,10,00.
  - Outputs: max=3, min=2, median=4, on 3 consecutive cycles; out_sol only on first.
- Bubbles: basic fill with 2 idle cycles between columns → single output 5, exactly 3 cycles after third column; out_valid pulse width 1.
- Mid-line resync:
  - Stimulus: 4 columns, then sol on a 5th column, then 2 more columns.
  - Response: 2 outputs from first line; the new line's first output (out_sol=1) only after its third column.
- Reset and width: assert rst_p during the second output of a line → all outputs 0 within the same cycle, no further out_valid. Repeat with DATA_W=10 using values 1023/0 with ties → median correct.
